// File: rtl/stage3_store_buffer_if.sv
// rtl/stage3_store_buffer_if.sv - memory-stage request and downstream bus signals of the store buffer
interface stage3_store_buffer_if;
    logic        cpu_ren;
    logic        cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byte_en;
    logic [31:0] cpu_rdata;
    logic        cpu_busy;
    logic        cpu_error;

    logic        bus_ren;
    logic        bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byte_en;
    logic [31:0] bus_rdata;
    logic        bus_busy;
    logic        bus_error;

    modport master (
        output cpu_ren, cpu_wen, cpu_addr, cpu_wdata, cpu_byte_en,
        input  cpu_rdata, cpu_busy, cpu_error,
        input  bus_ren, bus_wen, bus_addr, bus_wdata, bus_byte_en,
        output bus_rdata, bus_busy, bus_error
    );

    modport slave (
        input  cpu_ren, cpu_wen, cpu_addr, cpu_wdata, cpu_byte_en,
        output cpu_rdata, cpu_busy, cpu_error,
        output bus_ren, bus_wen, bus_addr, bus_wdata, bus_byte_en,
        input  bus_rdata, bus_busy, bus_error
    );
endinterface

// File: rtl/stage3_store_buffer.sv
// rtl/stage3_store_buffer.sv - store buffer between memory stage and bus; STORE_BUFFER_FWD_EN enables store-to-load forwarding
module stage3_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    stage3_store_buffer_if.slave sb,
    input  logic                 fence_drain,
    output logic                 drained,
    output logic                 store_fault,
    output logic [31:0]          fault_addr
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

    state_t        state;
    logic [31:0]   mem_addr  [DEPTH];
    logic [31:0]   mem_wdata [DEPTH];
    logic [3:0]    mem_be    [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    logic          bus_ren_q;
    logic          bus_wen_q;
    logic [31:0]   bus_addr_q;
    logic [31:0]   bus_wdata_q;
    logic [3:0]    bus_be_q;

    logic          full;
    logic          push;
    logic          pop;
    logic          hit;
    logic          fwd;
    logic          load_done;
    logic [31:0]   fwd_data;
    logic [PW-1:0] slot;
`ifdef STORE_BUFFER_FWD_EN
    logic [PW-1:0] fwd_idx;
`endif

    assign full      = (int'(count) == DEPTH);
    assign push      = sb.cpu_wen && !sb.cpu_ren && !full;
    assign pop       = (state == STORE) && !sb.bus_busy;
    assign drained   = (count == '0) && (state == IDLE);

    // Scan entries oldest to youngest so the last match is the youngest one.
    always_comb begin
        hit  = 1'b0;
        slot = '0;
`ifdef STORE_BUFFER_FWD_EN
        fwd_idx = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            slot = head + i[PW-1:0];
            if (i < int'(count) && mem_addr[slot][31:2] == sb.cpu_addr[31:2]) begin
                hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                fwd_idx = slot;
`endif
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    assign fwd = sb.cpu_ren && hit && !fence_drain && (state != LOAD) &&
                 ((mem_be[fwd_idx] & sb.cpu_byte_en) == sb.cpu_byte_en);
    assign fwd_data = mem_wdata[fwd_idx];
`else
    assign fwd      = 1'b0;
    assign fwd_data = '0;
`endif

    assign load_done = ((state == LOAD) && !sb.bus_busy) || fwd;

    always_comb begin
        sb.cpu_rdata = '0;
        sb.cpu_error = 1'b0;
        sb.cpu_busy  = 1'b0;
        if (sb.cpu_ren) begin
            sb.cpu_busy = !load_done;
            if (fwd) begin
                sb.cpu_rdata = fwd_data;
            end else if ((state == LOAD) && !sb.bus_busy) begin
                sb.cpu_rdata = sb.bus_rdata;
                sb.cpu_error = sb.bus_error;
            end
        end else if (sb.cpu_wen) begin
            sb.cpu_busy = full;
        end
    end

    // Entry storage carries no reset; validity comes from head/count alone.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_addr[tail]  <= sb.cpu_addr;
            mem_wdata[tail] <= sb.cpu_wdata;
            mem_be[tail]    <= sb.cpu_byte_en;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            bus_ren_q   <= 1'b0;
            bus_wen_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            store_fault <= 1'b0;
            fault_addr  <= '0;
        end else begin
            store_fault <= 1'b0;
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end

            // Bus request registers only move on a transition, so they hold while bus_busy.
            case (state)
                IDLE: begin
                    if (sb.cpu_ren && !hit && !fence_drain) begin
                        state       <= LOAD;
                        bus_ren_q   <= 1'b1;
                        bus_addr_q  <= sb.cpu_addr;
                        bus_wdata_q <= '0;
                        bus_be_q    <= sb.cpu_byte_en;
                    end else if (count != '0) begin
                        state       <= STORE;
                        bus_wen_q   <= 1'b1;
                        bus_addr_q  <= mem_addr[head];
                        bus_wdata_q <= mem_wdata[head];
                        bus_be_q    <= mem_be[head];
                    end
                end
                LOAD: begin
                    if (!sb.bus_busy) begin
                        state     <= IDLE;
                        bus_ren_q <= 1'b0;
                    end
                end
                STORE: begin
                    if (!sb.bus_busy) begin
                        state     <= IDLE;
                        bus_wen_q <= 1'b0;
                        if (sb.bus_error) begin
                            store_fault <= 1'b1;
                            fault_addr  <= bus_addr_q;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sb.bus_ren     = bus_ren_q;
    assign sb.bus_wen     = bus_wen_q;
    assign sb.bus_addr    = bus_addr_q;
    assign sb.bus_wdata   = bus_wdata_q;
    assign sb.bus_byte_en = bus_be_q;
endmodule

// File: tb/tb_stage3_store_buffer.sv
// tb/tb_stage3_store_buffer.sv - scoreboard bench for stage3_store_buffer against an architectural memory model
module tb_stage3_store_buffer;
    logic        CLK = 1'b0;
    logic        RST;
    logic        fence_drain;
    logic        drained;
    logic        store_fault;
    logic [31:0] fault_addr;

    stage3_store_buffer_if bif();

    stage3_store_buffer #(.DEPTH(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .sb          (bif),
        .fence_drain (fence_drain),
        .drained     (drained),
        .store_fault (store_fault),
        .fault_addr  (fault_addr)
    );

    always #5 CLK = ~CLK;

    typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] be;} st_t;
    typedef struct {logic [31:0] data; logic [31:0] mask; logic err;} ld_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] arch_mem [256];
    logic [31:0] bus_mem  [256];
    st_t         sq[$];
    ld_t         lq[$];
    int          wbeats = 0;
    int          ren_cycles = 0;
    int          fault_pulses = 0;
    int          busy_mode = 1;

    assign bif.bus_rdata = bus_mem[bif.bus_addr[9:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    // Bus slave: random back-pressure unless a directed test owns bus_busy.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (busy_mode == 0) bif.bus_busy = ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor: pops scoreboards on every observed completion.
    initial begin
        logic        have_prev;
        logic        prev_busy;
        logic        exp_fault;
        logic [31:0] exp_fault_addr;
        logic [69:0] prev_req;
        logic [69:0] cur_req;
        st_t         s;
        ld_t         l;
        have_prev = 1'b0;
        prev_busy = 1'b0;
        exp_fault = 1'b0;
        exp_fault_addr = '0;
        prev_req = '0;
        forever begin
            @(negedge CLK);
            cur_req = {bif.bus_ren, bif.bus_wen, bif.bus_addr, bif.bus_wdata, bif.bus_byte_en};
            if (RST) begin
                have_prev = 1'b0;
                exp_fault = 1'b0;
            end else begin
                check("store_fault", store_fault, exp_fault);
                if (exp_fault) check("fault_addr", fault_addr, exp_fault_addr);
                if (store_fault) fault_pulses++;
                exp_fault = 1'b0;
                if (have_prev && prev_busy && (prev_req[69] || prev_req[68]))
                    check("bus_hold", cur_req == prev_req, 1'b1);
                if (drained) check("drained_empty", sq.size(), 0);
                if (bif.bus_ren) ren_cycles++;
                if (bif.bus_wen && !bif.bus_busy) begin
                    wbeats++;
                    if (sq.size() == 0) begin
                        check("unexpected_write", bif.bus_addr, 32'hFFFF_FFFF);
                    end else begin
                        s = sq.pop_front();
                        check("wr_addr", bif.bus_addr, s.addr);
                        check("wr_data", bif.bus_wdata, s.data);
                        check("wr_be", bif.bus_byte_en, s.be);
                        if (!bif.bus_error) begin
                            bus_mem[s.addr[9:2]] = (bus_mem[s.addr[9:2]] & ~be_mask(s.be)) |
                                                   (s.data & be_mask(s.be));
                        end else begin
                            exp_fault = 1'b1;
                            exp_fault_addr = s.addr;
                        end
                    end
                end
                if (bif.cpu_ren && !bif.cpu_busy) begin
                    if (lq.size() == 0) begin
                        check("unexpected_load", bif.cpu_rdata, 32'hFFFF_FFFF);
                    end else begin
                        l = lq.pop_front();
                        check("ld_data", bif.cpu_rdata & l.mask, l.data & l.mask);
                        check("ld_error", bif.cpu_error, l.err);
                    end
                end
                have_prev = 1'b1;
            end
            prev_busy = bif.bus_busy;
            prev_req  = cur_req;
        end
    end

    task automatic wait_accept(input string name, output int waited);
        waited = 0;
        while (1) begin
            @(negedge CLK);
            if (!bif.cpu_busy) break;
            waited++;
            if (waited > 200) begin
                check({name, "_timeout"}, waited, 0);
                break;
            end
        end
    endtask

    task automatic record_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        sq.push_back('{a, d, be});
        arch_mem[a[9:2]] = (arch_mem[a[9:2]] & ~be_mask(be)) | (d & be_mask(be));
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int w;
        bif.cpu_wen = 1'b1;
        bif.cpu_addr = a;
        bif.cpu_wdata = d;
        bif.cpu_byte_en = be;
        wait_accept("store", w);
        @(posedge CLK);
        #1;
        bif.cpu_wen = 1'b0;
        if (w <= 200) record_store(a, d, be);
    endtask

    task automatic sw_try(input logic [31:0] a, input logic [31:0] d, output logic acc);
        bif.cpu_wen = 1'b1;
        bif.cpu_addr = a;
        bif.cpu_wdata = d;
        bif.cpu_byte_en = 4'hF;
        @(negedge CLK);
        acc = !bif.cpu_busy;
        @(posedge CLK);
        #1;
        if (acc) record_store(a, d, 4'hF);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [3:0] be, input logic err, output int waited);
        lq.push_back('{arch_mem[a[9:2]], be_mask(be), err});
        bif.cpu_ren = 1'b1;
        bif.cpu_addr = a;
        bif.cpu_byte_en = be;
        wait_accept("load", waited);
        @(posedge CLK);
        #1;
        bif.cpu_ren = 1'b0;
    endtask

    task automatic wait_drained();
        int n = 0;
        while (1) begin
            @(negedge CLK);
            if (drained && sq.size() == 0) break;
            n++;
            if (n > 500) begin
                check("drain_timeout", n, 0);
                break;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          w0;
        int          r0;
        int          f0;
        logic        acc;
        int          r;
        logic [31:0] a;
        logic [3:0]  be;

        for (int i = 0; i < 256; i++) begin
            bus_mem[i]  = 32'h5A00_0000 ^ (i * 32'h0001_0203);
            arch_mem[i] = bus_mem[i];
        end
        RST = 1'b1;
        fence_drain = 1'b0;
        bif.cpu_ren = 1'b0;
        bif.cpu_wen = 1'b0;
        bif.cpu_addr = '0;
        bif.cpu_wdata = '0;
        bif.cpu_byte_en = '0;
        bif.bus_busy = 1'b0;
        bif.bus_error = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        @(negedge CLK);
        check("rst_bus_ren", bif.bus_ren, 0);
        check("rst_bus_wen", bif.bus_wen, 0);
        check("rst_cpu_error", bif.cpu_error, 0);
        check("rst_drained", drained, 1);
        check("rst_fault_addr", fault_addr, 0);
        check("rst_cpu_busy", bif.cpu_busy, 0);
        @(posedge CLK);
        #1;

        // Four back-to-back stores with an always-ready bus.
        w0 = wbeats;
        for (int k = 0; k < 4; k++) begin
            sw_try(32'h100 + 32'(4 * k), $urandom, acc);
            check("sw_nostall", acc, 1);
        end
        bif.cpu_wen = 1'b0;
        wait_drained();
        check("sw_beats", wbeats - w0, 4);
        check("sw_drained", drained, 1);

        // Fill with the bus stalled, then a fifth store waits for the first pop.
        bif.bus_busy = 1'b1;
        for (int k = 0; k < 4; k++) do_store(32'h110 + 32'(4 * k), $urandom, 4'hF);
        for (int k = 0; k < 3; k++) begin
            sw_try(32'h104, 32'hCAFE_0005, acc);
            check("full_stall", acc, 0);
        end
        bif.bus_busy = 1'b0;
        sw_try(32'h104, 32'hCAFE_0005, acc);
        check("full_pop_cycle", acc, 0);
        bif.bus_busy = 1'b1;
        sw_try(32'h104, 32'hCAFE_0005, acc);
        check("full_accept_after_pop", acc, 1);
        bif.cpu_wen = 1'b0;
        bif.bus_busy = 1'b0;
        wait_drained();

        // Store then load of the same word.
        do_store(32'h200, 32'hDEAD_BEEF, 4'hF);
        r0 = ren_cycles;
        do_load(32'h200, 4'hF, 1'b0, w);
`ifdef STORE_BUFFER_FWD_EN
        check("fwd_no_wait", w, 0);
        check("fwd_no_bus_ren", ren_cycles - r0, 0);
`else
        check("nofwd_stall", w > 0, 1);
        check("nofwd_bus_read", ren_cycles - r0 > 0, 1);
`endif
        wait_drained();

        // A non-hitting load overtakes buffered stores.
        bif.bus_busy = 1'b1;
        do_store(32'h100, 32'h1111_1111, 4'hF);
        do_store(32'h100, 32'h2222_2222, 4'hF);
        w0 = wbeats;
        lq.push_back('{arch_mem[8'hC0], 32'hFFFF_FFFF, 1'b0});
        bif.cpu_ren = 1'b1;
        bif.cpu_addr = 32'h300;
        bif.cpu_byte_en = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("ovt_wait_store", bif.cpu_busy, 1);
            @(posedge CLK);
            #1;
        end
        bif.bus_busy = 1'b0;
        @(negedge CLK);
        check("ovt_pop_cycle", bif.cpu_busy, 1);
        @(posedge CLK);
        #1;
        bif.bus_busy = 1'b1;
        @(negedge CLK);
        check("ovt_idle_cycle", bif.cpu_busy, 1);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("ovt_bus_ren", bif.bus_ren, 1);
        check("ovt_bus_wen", bif.bus_wen, 0);
        check("ovt_bus_addr", bif.bus_addr, 32'h300);
        check("ovt_busy_held", bif.cpu_busy, 1);
        @(posedge CLK);
        #1;
        bif.bus_busy = 1'b0;
        @(negedge CLK);
        check("ovt_complete", bif.cpu_busy, 0);
        check("ovt_one_store_before", wbeats - w0, 1);
        @(posedge CLK);
        #1;
        bif.cpu_ren = 1'b0;
        wait_drained();
        check("ovt_all_stores", wbeats - w0, 2);

        // Fence: loads refused while stores drain.
        fence_drain = 1'b1;
        do_store(32'h104, $urandom, 4'hF);
        do_store(32'h108, $urandom, 4'hF);
        r0 = ren_cycles;
        lq.push_back('{arch_mem[8'hC3], 32'hFFFF_FFFF, 1'b0});
        bif.cpu_ren = 1'b1;
        bif.cpu_addr = 32'h30C;
        bif.cpu_byte_en = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            check("fence_refuse", bif.cpu_busy, 1);
            @(posedge CLK);
            #1;
        end
        check("fence_drained", drained, 1);
        check("fence_no_read", ren_cycles - r0, 0);
        fence_drain = 1'b0;
        wait_accept("fence_load", w);
        @(posedge CLK);
        #1;
        bif.cpu_ren = 1'b0;

        // Store bus error, then load bus error.
        wait_drained();
        f0 = fault_pulses;
        bif.bus_error = 1'b1;
        do_store(32'h400, 32'h1234_5678, 4'hF);
        wait_drained();
        check("fault_pulses", fault_pulses - f0, 1);
        check("fault_latched", fault_addr, 32'h400);
        do_load(32'h300, 4'hF, 1'b1, w);
        bif.bus_error = 1'b0;

        // Randomized mix against the architectural model.
        busy_mode = 0;
        for (int n = 0; n < 250; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #1;
            a = 32'h100 + 32'(4 * $urandom_range(0, 7));
            r = $urandom_range(1, 15);
            be = r[3:0];
            if ($urandom_range(0, 1) == 0) do_store(a, $urandom, be);
            else do_load(a, be, 1'b0, w);
        end
        wait_drained();
        busy_mode = 1;
        @(posedge CLK);
        #1;
        bif.bus_busy = 1'b0;

        // Reset while three stores are buffered and bus_wen is active.
        bif.bus_busy = 1'b1;
        do_store(32'h100, $urandom, 4'hF);
        do_store(32'h104, $urandom, 4'hF);
        do_store(32'h108, $urandom, 4'hF);
        @(negedge CLK);
        check("prerst_bus_wen", bif.bus_wen, 1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        sq.delete();
        bif.bus_busy = 1'b0;
        @(negedge CLK);
        check("midrst_bus_wen", bif.bus_wen, 0);
        check("midrst_bus_ren", bif.bus_ren, 0);
        check("midrst_cpu_error", bif.cpu_error, 0);
        check("midrst_drained", drained, 1);
        w0 = wbeats;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        check("midrst_no_writes", wbeats - w0, 0);
        check("midrst_still_drained", drained, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stage3_store_buffer.md
STAGE3_STORE_BUFFER -- requirements
Module: stage3_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning store entries; power of two, 2..16.
REQ-002 SHALL have port CLK  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port RST  in  1  reset; synchronous, active-high.
REQ-004 SHALL have ports cpu_ren, cpu_wen  in  1 each  load/store request from the memory stage.
REQ-005 SHALL have ports cpu_addr, cpu_wdata  in  32 each  request address and store data.
REQ-006 SHALL have port cpu_byte_en  in  4  byte lanes.
REQ-007 SHALL have ports cpu_rdata out 32, cpu_busy out 1, cpu_error out 1  load data, stall to the memory stage, load fault.
REQ-008 SHALL have ports bus_ren, bus_wen out 1; bus_addr, bus_wdata out 32; bus_byte_en out 4  downstream bus request.
REQ-009 SHALL have ports bus_rdata in 32, bus_busy in 1, bus_error in 1  downstream response.
REQ-010 SHALL have port fence_drain  in  1  drain request from fence logic.
REQ-011 SHALL have ports drained out 1, store_fault out 1, fault_addr out 32  buffer empty and idle; one-cycle store bus error pulse; faulting store address.

Function
REQ-012 SHALL hold entries {addr, wdata, byte_en} in a circular FIFO with head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, and count of log2(DEPTH)+1 bits.
REQ-013 SHALL accept a store (cpu_wen) with cpu_busy=0 in the same cycle when count<DEPTH, writing it at the tail on that edge.
REQ-014 SHALL assert cpu_busy for a store when count==DEPTH; full is evaluated from the registered count only, so a same-cycle pop does not admit a store.
REQ-015 SHALL keep count unchanged on a simultaneous push and pop.
REQ-016 SHALL run an FSM with states IDLE, LOAD, STORE; no bus request is driven in IDLE.
REQ-017 SHALL transition IDLE->LOAD on cpu_ren with no address hit and fence_drain=0; otherwise IDLE->STORE when count>0; otherwise stay IDLE.
REQ-018 SHALL, in LOAD, drive bus_ren=1 with cpu_addr/cpu_byte_en; when bus_busy=0, drive cpu_rdata=bus_rdata, cpu_busy=0, cpu_error=bus_error, then go to IDLE.
REQ-019 SHALL, in STORE, drive bus_wen=1 with the head entry; when bus_busy=0, pop the head and go to IDLE.
REQ-020 SHALL never change bus_addr/bus_wdata/bus_byte_en/bus_ren/bus_wen while bus_busy=1.
REQ-021 SHALL detect a hit when any valid entry matches cpu_addr[31:2]; a hitting load stalls (cpu_busy=1) until no valid entry matches.
REQ-022 SHALL hold cpu_busy=1 for every load cycle not completing per REQ-018 or REQ-032.
REQ-023 SHALL, while fence_drain=1, refuse loads (cpu_busy=1) and drain stores; stores remain accepted per REQ-013.
REQ-024 SHALL drive drained=1 exactly when count==0 and state is IDLE.
REQ-025 SHALL, on a STORE completion with bus_error=1, pulse store_fault for one cycle, latch fault_addr with the entry address, and still pop the entry.
REQ-026 SHALL ignore cpu_wen when cpu_ren and cpu_wen are asserted together; the request is treated as a load.

Reset
REQ-027 SHALL, with RST=1 at an edge, set state IDLE, head, tail and count 0, store_fault 0, fault_addr 0; any buffered stores are discarded.
REQ-028 SHALL drive bus_ren=0, bus_wen=0, cpu_error=0 and drained=1 in the cycle after reset, including reset mid-transaction.

Configuration
REQ-029 SHALL use macro STORE_BUFFER_FWD_EN to control store-to-load forwarding.
REQ-030 SHALL, without STORE_BUFFER_FWD_EN, stall every hitting load per REQ-021.
REQ-031 SHALL, with STORE_BUFFER_FWD_EN, select the youngest matching entry for a hitting load.
REQ-032 SHALL, with STORE_BUFFER_FWD_EN, complete the load in the same cycle with cpu_rdata=entry wdata, cpu_busy=0 and no bus access, when that entry's byte_en covers cpu_byte_en; otherwise the load stalls per REQ-021.

Verification
REQ-033 SHALL cover: 4 back-to-back SW to 0x100..0x10C with bus_busy=0 -> each accepted without stall, 4 bus_wen beats in order, drained=1 after last.
REQ-034 SHALL cover: 5th SW while full (DEPTH=4, bus_busy=1) -> cpu_busy=1 until first pop, then accepted next cycle.
REQ-035 SHALL cover: SW 0xDEADBEEF to 0x200 then LW 0x200 -> no FWD, load stalls until drain, cpu_rdata=bus_rdata; with FWD, cpu_rdata=0xDEADBEEF, cpu_busy=0, no bus_ren.
REQ-036 SHALL cover: LW 0x300 with 2 buffered stores to 0x100 -> bus_ren issued before those stores drain, completion when bus_busy falls.
REQ-037 SHALL cover: store to 0x400 with bus_error=1 on completion -> store_fault one cycle, fault_addr=0x400, count decrements.
REQ-038 SHALL cover: RST asserted with 3 entries and bus_wen active -> next cycle bus_wen=0, count=0, drained=1.
